// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the two-requester SRAM arbiter: response FSM states,
// requester indices and the default starvation limit.
package mem_arbiter_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RESP = 1'b1
  } state_e;

  localparam logic REQ_INST     = 1'b0;
  localparam logic REQ_DATA     = 1'b1;
  localparam int   MAX_WAIT_DEF = 4;
  localparam int   WAIT_W       = 4;

endpackage

// File: rtl/mem_arbiter_wait_cnt.sv
// Saturating per-requester wait counter; sat_o flags a requester that has
// waited MAX_WAIT cycles and must win its next conflict.
module arb_wait_cnt
  import mem_arbiter_pkg::*;
#(
  parameter int MAX_WAIT = MAX_WAIT_DEF
) (
  input  logic clk,
  input  logic resetn,
  input  logic req_i,
  input  logic gnt_i,
  output logic sat_o
);

  localparam logic [WAIT_W-1:0] SAT_V = WAIT_W'(MAX_WAIT);

  logic [WAIT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (!req_i || gnt_i) begin
      cnt_d = '0;
    end else if (cnt_q != SAT_V) begin
      cnt_d = cnt_q + WAIT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign sat_o = (cnt_q == SAT_V);

endmodule

// File: rtl/mem_arbiter.sv
// Two-requester (instruction / data) arbiter for one single-port SRAM with a
// 1-cycle read latency. Define MEM_ARB_DATA_PRIO_EN for fixed data priority;
// otherwise conflicts are resolved round-robin. Starvation overrides both.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int ADDR_W   = 32,
  parameter int MAX_WAIT = MAX_WAIT_DEF
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              i_req,
  input  logic [3:0]        i_wen,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [31:0]       i_wdata,
  input  logic              d_req,
  input  logic [3:0]        d_wen,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [31:0]       d_wdata,
  output logic              i_gnt,
  output logic              i_rvalid,
  output logic [31:0]       i_rdata,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [31:0]       d_rdata,
  output logic              sram_en,
  output logic [3:0]        sram_wen,
  output logic [ADDR_W-1:0] sram_addr,
  output logic [31:0]       sram_wdata,
  input  logic [31:0]       sram_rdata
);

  state_e state_q;
  logic   owner_q;
  logic   wr_q;
  logic   last_gnt_q;
  logic   i_sat, d_sat;
  logic   win_data;

  arb_wait_cnt #(.MAX_WAIT(MAX_WAIT)) u_i_wait (
    .clk    (clk),
    .resetn (resetn),
    .req_i  (i_req),
    .gnt_i  (i_gnt),
    .sat_o  (i_sat)
  );

  arb_wait_cnt #(.MAX_WAIT(MAX_WAIT)) u_d_wait (
    .clk    (clk),
    .resetn (resetn),
    .req_i  (d_req),
    .gnt_i  (d_gnt),
    .sat_o  (d_sat)
  );

  // Conflict winner: starvation first, then the configured policy.
  always_comb begin
    win_data = 1'b0;
    if (i_sat && d_sat) begin
      win_data = (last_gnt_q == REQ_INST);
    end else if (i_sat) begin
      win_data = 1'b0;
    end else if (d_sat) begin
      win_data = 1'b1;
    end else begin
`ifdef MEM_ARB_DATA_PRIO_EN
      win_data = 1'b1;
`else
      win_data = (last_gnt_q == REQ_INST);
`endif
    end
  end

  // Grants are combinational, so they are forced low while reset is held.
  assign i_gnt = resetn & i_req & (~d_req | ~win_data);
  assign d_gnt = resetn & d_req & (~i_req | win_data);

  always_comb begin
    sram_en    = 1'b0;
    sram_wen   = 4'h0;
    sram_addr  = '0;
    sram_wdata = 32'h0;
    if (d_gnt) begin
      sram_en    = 1'b1;
      sram_wen   = d_wen;
      sram_addr  = d_addr;
      sram_wdata = d_wdata;
    end else if (i_gnt) begin
      sram_en    = 1'b1;
      sram_wen   = i_wen;
      sram_addr  = i_addr;
      sram_wdata = i_wdata;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q    <= IDLE;
      owner_q    <= REQ_INST;
      wr_q       <= 1'b0;
      last_gnt_q <= REQ_DATA;
    end else if (i_gnt || d_gnt) begin
      state_q    <= RESP;
      owner_q    <= d_gnt;
      wr_q       <= (sram_wen != 4'h0);
      last_gnt_q <= d_gnt;
    end else begin
      state_q    <= IDLE;
    end
  end

  assign i_rvalid = (state_q == RESP) && (owner_q == REQ_INST);
  assign d_rvalid = (state_q == RESP) && (owner_q == REQ_DATA);
  // A write still returns an rvalid pulse, but with zero data.
  assign i_rdata  = (i_rvalid && !wr_q) ? sram_rdata : 32'h0;
  assign d_rdata  = (d_rvalid && !wr_q) ? sram_rdata : 32'h0;

endmodule

// File: tb/tb_mem_arbiter.sv
// Randomized bench for mem_arbiter with a behavioural arbitration/SRAM model,
// plus directed scenarios with literal expectations.
module tb_mem_arbiter;

  localparam int ADDR_W   = 32;
  localparam int MAX_WAIT = 4;

  logic              clk = 1'b0;
  logic              resetn = 1'b0;
  logic              i_req, d_req;
  logic [3:0]        i_wen, d_wen;
  logic [ADDR_W-1:0] i_addr, d_addr;
  logic [31:0]       i_wdata, d_wdata;
  logic              i_gnt, i_rvalid, d_gnt, d_rvalid;
  logic [31:0]       i_rdata, d_rdata;
  logic              sram_en;
  logic [3:0]        sram_wen;
  logic [ADDR_W-1:0] sram_addr;
  logic [31:0]       sram_wdata, sram_rdata;

  logic [31:0] sram_mem [16];
  logic [31:0] mdl_mem  [16];

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  mem_arbiter #(.ADDR_W(ADDR_W), .MAX_WAIT(MAX_WAIT)) dut (
    .clk(clk), .resetn(resetn),
    .i_req(i_req), .i_wen(i_wen), .i_addr(i_addr), .i_wdata(i_wdata),
    .d_req(d_req), .d_wen(d_wen), .d_addr(d_addr), .d_wdata(d_wdata),
    .i_gnt(i_gnt), .i_rvalid(i_rvalid), .i_rdata(i_rdata),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .sram_en(sram_en), .sram_wen(sram_wen), .sram_addr(sram_addr),
    .sram_wdata(sram_wdata), .sram_rdata(sram_rdata)
  );

  // Behavioural single-port SRAM with byte enables and 1-cycle read latency.
  always @(posedge clk) begin
    if (sram_en) begin
      if (sram_wen != 4'h0) begin
        for (int b = 0; b < 4; b++)
          if (sram_wen[b]) sram_mem[sram_addr[5:2]][b*8 +: 8] <= sram_wdata[b*8 +: 8];
      end else begin
        sram_rdata <= sram_mem[sram_addr[5:2]];
      end
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: state reflects what must hold after the next rising edge.
  int          wcnt [2];
  int          last_win;
  bit          pend;
  int          pend_own;
  bit          pend_wr;
  logic [31:0] pend_rd;

  always @(negedge clk) begin : model
    int          win;
    logic [3:0]  e_wen;
    logic [31:0] e_addr, e_wd;
    logic [31:0] e_ird, e_drd;
    int          idx;
    if (!resetn) begin
      wcnt[0] = 0; wcnt[1] = 0; last_win = 1; pend = 0;
      check("rst_i_gnt", i_gnt, 0);
      check("rst_d_gnt", d_gnt, 0);
      check("rst_sram_en", sram_en, 0);
      check("rst_sram_addr", sram_addr, 0);
      check("rst_i_rvalid", i_rvalid, 0);
      check("rst_d_rvalid", d_rvalid, 0);
    end else begin
      win = -1;
      if (i_req && d_req) begin
        if (wcnt[0] == MAX_WAIT && wcnt[1] == MAX_WAIT) win = 1 - last_win;
        else if (wcnt[0] == MAX_WAIT) win = 0;
        else if (wcnt[1] == MAX_WAIT) win = 1;
        else begin
`ifdef MEM_ARB_DATA_PRIO_EN
          win = 1;
`else
          win = 1 - last_win;
`endif
        end
      end else if (i_req) win = 0;
      else if (d_req) win = 1;

      e_wen  = (win == 0) ? i_wen   : (win == 1) ? d_wen   : 4'h0;
      e_addr = (win == 0) ? i_addr  : (win == 1) ? d_addr  : 32'h0;
      e_wd   = (win == 0) ? i_wdata : (win == 1) ? d_wdata : 32'h0;
      e_ird  = (pend && pend_own == 0 && !pend_wr) ? pend_rd : 32'h0;
      e_drd  = (pend && pend_own == 1 && !pend_wr) ? pend_rd : 32'h0;

      check("i_gnt", i_gnt, (win == 0));
      check("d_gnt", d_gnt, (win == 1));
      check("sram_en", sram_en, (win >= 0));
      check("sram_wen", sram_wen, e_wen);
      check("sram_addr", sram_addr, e_addr);
      check("sram_wdata", sram_wdata, e_wd);
      check("i_rvalid", i_rvalid, (pend && pend_own == 0));
      check("d_rvalid", d_rvalid, (pend && pend_own == 1));
      check("i_rdata", i_rdata, e_ird);
      check("d_rdata", d_rdata, e_drd);

      for (int r = 0; r < 2; r++) begin
        if (((r == 0) ? i_req : d_req) && win != r)
          wcnt[r] = (wcnt[r] < MAX_WAIT) ? wcnt[r] + 1 : MAX_WAIT;
        else
          wcnt[r] = 0;
      end
      pend = (win >= 0);
      if (win >= 0) begin
        idx      = int'(e_addr[5:2]);
        last_win = win;
        pend_own = win;
        pend_wr  = (e_wen != 4'h0);
        pend_rd  = mdl_mem[idx];
        for (int b = 0; b < 4; b++)
          if (e_wen[b]) mdl_mem[idx][b*8 +: 8] = e_wd[b*8 +: 8];
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic ig, dg;
  logic exp_i, prev_i;

  initial begin
    for (int i = 0; i < 16; i++) begin
      sram_mem[i] <= 32'h1000_0000 + i;
      mdl_mem[i]  = 32'h1000_0000 + i;
    end
    i_req = 1'b1; i_wen = 4'h0; i_addr = '0; i_wdata = 32'h0;
    d_req = 1'b0; d_wen = 4'h0; d_addr = '0; d_wdata = 32'h0;
    resetn = 1'b0;

    // Reset state: combinational grant suppressed even with a request pending.
    tick(); tick();
    check("reset_i_gnt_held", i_gnt, 0);
    check("reset_sram_en_held", sram_en, 0);
    check("reset_last_gnt", dut.last_gnt_q, 1);
    check("reset_i_cnt", dut.u_i_wait.cnt_q, 0);
    i_req = 1'b0;
    tick();
    resetn = 1'b1;

    // Single instruction read.
    tick();
    i_req = 1'b1; i_addr = 32'h100; i_wen = 4'h0;
    #1;
    check("single_i_gnt", i_gnt, 1);
    check("single_sram_addr", sram_addr, 32'h100);
    check("single_sram_en", sram_en, 1);
    tick();
    i_req = 1'b0;
    #1;
    check("single_i_rvalid", i_rvalid, 1);
    check("single_i_rdata", i_rdata, 32'h1000_0000);

    // Data write.
    d_req = 1'b1; d_wen = 4'hF; d_addr = 32'h20; d_wdata = 32'hDEAD_BEEF;
    #1;
    check("write_d_gnt", d_gnt, 1);
    check("write_sram_wen", sram_wen, 4'hF);
    check("write_sram_wdata", sram_wdata, 32'hDEAD_BEEF);
    tick();
    d_req = 1'b0; d_wen = 4'h0; d_wdata = 32'h0; d_addr = '0;
    #1;
    check("write_d_rvalid", d_rvalid, 1);
    check("write_d_rdata", d_rdata, 0);
    check("idle_sram_en", sram_en, 0);
    check("idle_sram_addr", sram_addr, 0);
    check("idle_sram_wdata", sram_wdata, 0);
    tick();
    check("idle_i_rvalid", i_rvalid, 0);
    check("idle_d_rvalid", d_rvalid, 0);

    // Both requesters held continuously from a fresh reset.
    resetn = 1'b0;
    tick();
    resetn = 1'b1;
    i_req = 1'b1; i_addr = 32'h4; d_req = 1'b1; d_addr = 32'h8;
    prev_i = 1'b0;
    for (int k = 0; k < 10; k++) begin
      #1;
`ifdef MEM_ARB_DATA_PRIO_EN
      exp_i = (k % 5 == 4);
`else
      exp_i = (k % 2 == 0);
`endif
      check("conflict_i_gnt", i_gnt, exp_i);
      check("conflict_d_gnt", d_gnt, !exp_i);
      if (k > 0) check("conflict_i_rvalid", i_rvalid, prev_i);
      prev_i = exp_i;
      tick();
    end
    i_req = 1'b0; d_req = 1'b0;
    tick();

    // Reset asserted the cycle after a read grant.
    i_req = 1'b1; i_addr = 32'h10;
    #1;
    check("rstmid_i_gnt", i_gnt, 1);
    tick();
    i_req = 1'b0; resetn = 1'b0;
    #1;
    check("rstmid_i_rvalid_in_reset", i_rvalid, 0);
    tick();
    resetn = 1'b1;
    tick();
    check("rstmid_i_rvalid_after", i_rvalid, 0);
    check("rstmid_d_rvalid_after", d_rvalid, 0);
    check("rstmid_last_gnt", dut.last_gnt_q, 1);
    check("rstmid_i_cnt", dut.u_i_wait.cnt_q, 0);
    check("rstmid_d_cnt", dut.u_d_wait.cnt_q, 0);

    // Randomized traffic; requesters hold their payload until granted.
    for (int cyc = 0; cyc < 1500; cyc++) begin
      @(negedge clk);
      ig = i_gnt; dg = d_gnt;
      @(posedge clk);
      #1;
      resetn = ($urandom_range(0, 79) != 0);
      if (!i_req || ig) begin
        i_req   = ($urandom_range(0, 3) != 0);
        i_wen   = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'h0;
        i_addr  = ADDR_W'($urandom_range(0, 15)) << 2;
        i_wdata = $urandom;
      end
      if (!d_req || dg) begin
        d_req   = ($urandom_range(0, 3) != 0);
        d_wen   = ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'h0;
        d_addr  = ADDR_W'($urandom_range(0, 15)) << 2;
        d_wdata = $urandom;
      end
    end

    resetn = 1'b1; i_req = 1'b0; d_req = 1'b0;
    repeat (3) tick();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
